// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle for the multi-cycle EX-stage ALU.
// master drives operands and result acceptance; slave is the ALU.
interface alu_mc_if #(
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [OP_WIDTH-1:0] in_op;
    logic [WIDTH-1:0]    in_a;
    logic [WIDTH-1:0]    in_b;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;
    logic                out_zero;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_zero
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_zero
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring divide behind valid/ready handshakes.
//
// state  | meaning
// IDLE   | waiting for operands, in_ready high
// BUSY   | one multiply/divide iteration per cycle, cnt_q counts down to 0
// DONE   | result registered and presented, waiting for out_ready
module alu_mc #(
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = 4
) (
    input logic     clk,
    input logic     rst_n,
    alu_mc_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [OP_WIDTH-1:0] OP_AND   = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_OR    = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_NOR   = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_SLT   = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_SLTU  = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_XOR   = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_SLL   = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_SRL   = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] OP_SRA   = OP_WIDTH'(10);
    localparam logic [OP_WIDTH-1:0] OP_MUL   = OP_WIDTH'(11);
    localparam logic [OP_WIDTH-1:0] OP_MULHU = OP_WIDTH'(12);
    localparam logic [OP_WIDTH-1:0] OP_DIVU  = OP_WIDTH'(13);
    localparam logic [OP_WIDTH-1:0] OP_REMU  = OP_WIDTH'(14);

    logic [1:0]          state_q, state_d;
    logic [SHW-1:0]      cnt_q, cnt_d;
    logic [OP_WIDTH-1:0] op_q, op_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [2*WIDTH-1:0]  prod_q, prod_d;
    logic [WIDTH-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                zero_q, zero_d;

    logic                    accept;
    logic                    is_mul;
    logic                    is_div;
    logic [SHW-1:0]          sh;
    logic signed [WIDTH-1:0] sra_res;
    logic [WIDTH-1:0]        res_single;
    logic [WIDTH:0]          mul_sum;
    logic [WIDTH:0]          div_trial;
    logic [WIDTH-1:0]        div_shift;

    assign bus.in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_data  = data_q;
    assign bus.out_zero  = zero_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign sh     = bus.in_b[SHW-1:0];
    assign is_mul = (bus.in_op == OP_MUL) || (bus.in_op == OP_MULHU);
    // A zero divisor is answered immediately and never enters BUSY.
    assign is_div = ((bus.in_op == OP_DIVU) || (bus.in_op == OP_REMU)) && (bus.in_b != '0);

    always_comb begin
        sra_res    = $signed(bus.in_a) >>> sh;
        res_single = '0;
        case (bus.in_op)
            OP_AND:  res_single = bus.in_a & bus.in_b;
            OP_OR:   res_single = bus.in_a | bus.in_b;
            OP_ADD:  res_single = bus.in_a + bus.in_b;
            OP_SUB:  res_single = bus.in_a - bus.in_b;
            OP_NOR:  res_single = ~(bus.in_a | bus.in_b);
            OP_SLT:  res_single = {{(WIDTH-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
            OP_SLTU: res_single = {{(WIDTH-1){1'b0}}, (bus.in_a < bus.in_b)};
            OP_XOR:  res_single = bus.in_a ^ bus.in_b;
            OP_SLL:  res_single = bus.in_a << sh;
            OP_SRL:  res_single = bus.in_a >> sh;
            OP_SRA:  res_single = sra_res;
            OP_DIVU: res_single = '1;
            OP_REMU: res_single = bus.in_a;
            default: res_single = '0;
        endcase
    end

    // Datapath for one iteration: shift-add partial product and restoring divide step.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : {WIDTH{1'b0}})};
        div_trial = {rem_q, a_q[WIDTH-1]} - {1'b0, b_q};
        div_shift = {rem_q[WIDTH-2:0], a_q[WIDTH-1]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        data_d  = data_q;
        zero_d  = zero_q;
        case (state_q)
            S_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if ((op_q == OP_MUL) || (op_q == OP_MULHU)) begin
                    prod_d = {mul_sum, prod_q[WIDTH-1:1]};
                    b_d    = b_q >> 1;
                end else if (!div_trial[WIDTH]) begin
                    rem_d = div_trial[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = div_shift;
                    a_d   = {a_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    case (op_q)
                        OP_MUL:   data_d = prod_d[WIDTH-1:0];
                        OP_MULHU: data_d = prod_d[2*WIDTH-1:WIDTH];
                        OP_DIVU:  data_d = a_d;
                        default:  data_d = rem_d;
                    endcase
                    zero_d = (data_d == '0);
                end
            end
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (is_mul || is_div) begin
                        state_d = S_BUSY;
                        cnt_d   = SHW'(WIDTH - 1);
                        op_d    = bus.in_op;
                        a_d     = bus.in_a;
                        b_d     = bus.in_b;
                        prod_d  = '0;
                        rem_d   = '0;
                    end else begin
                        state_d = S_DONE;
                        data_d  = res_single;
                        zero_d  = (res_single == '0);
                    end
                end else if ((state_q == S_DONE) && bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: expected results are queued on accept and
// compared when the result handshake completes.
module tb_alu_mc;
    localparam int W = 32;

    localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3;
    localparam logic [3:0] OP_NOR = 4'd4, OP_SLT = 4'd5, OP_SLTU = 4'd6, OP_XOR = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8, OP_SRL = 4'd9, OP_SRA = 4'd10, OP_MUL = 4'd11;
    localparam logic [3:0] OP_MULHU = 4'd12, OP_DIVU = 4'd13, OP_REMU = 4'd14, OP_NOP = 4'd15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(W), .OP_WIDTH(4)) bus ();
    alu_mc #(.WIDTH(W), .OP_WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errs = 0;
    int checks = 0;
    int res_cnt = 0;
    int cyc = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Result monitor: a completed output handshake pops the oldest expectation.
    initial forever begin
        logic [W-1:0] e;
        @(negedge clk);
        #2;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("data", bus.out_data, e);
                chk("zero", bus.out_zero, (e == '0));
                res_cnt++;
            end
        end
    end

    // Call at a falling edge; returns just after the rising edge that accepts.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e);
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        #1;
        for (int i = 0; i < 100; i++) begin
            if (bus.in_ready) begin
                exp_q.push_back(e);
                @(posedge clk);
                return;
            end
            @(negedge clk);
            #1;
        end
        chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_result(output int n, output int nb);
        n  = 0;
        nb = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) bus.in_valid = 1'b0;
            #2;
            n++;
            if (bus.out_valid) return;
            if (!bus.in_ready) nb++;
        end
        chk("result_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_one(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] e, input int lat);
        int n, nb;
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(op, a, b, e);
        wait_result(n, nb);
        chk("latency", n, lat);
        chk("stall_cycles", nb, lat - 1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        int n, nb, r0, c0;
        logic [63:0] p;
        logic [W-1:0] x, y;

        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_out_zero", bus.out_zero, 1'b1);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        run_one(OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1);
        run_one(OP_SUB,  32'd5, 32'd5, 32'd0, 1);
        run_one(OP_NOR,  32'd0, 32'd0, 32'hFFFF_FFFF, 1);
        run_one(OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        run_one(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        run_one(OP_SRA,  32'h8000_0000, 32'h24, 32'hF800_0000, 1);
        run_one(OP_SRL,  32'h8000_0000, 32'h24, 32'h0800_0000, 1);
        run_one(OP_SLL,  32'h0000_0001, 32'h21, 32'h0000_0002, 1);
        run_one(OP_AND,  32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 1);
        run_one(OP_OR,   32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1);
        run_one(OP_XOR,  32'hFFFF_0000, 32'h0FF0_0FF0, 32'hF00F_0FF0, 1);
        run_one(OP_NOP,  32'h1234, 32'h5678, 32'd0, 1);

        run_one(OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
        run_one(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        x = 32'h1234_5678;
        y = 32'h9ABC_DEF0;
        p = {32'd0, x} * {32'd0, y};
        run_one(OP_MUL,   x, y, p[31:0], 33);
        run_one(OP_MULHU, x, y, p[63:32], 33);

        run_one(OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_one(OP_REMU, 32'd100, 32'd7, 32'd2, 33);
        x = 32'hDEAD_BEEF;
        y = 32'h0000_1234;
        run_one(OP_DIVU, x, y, x / y, 33);
        run_one(OP_REMU, x, y, x % y, 33);
        run_one(OP_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
        run_one(OP_REMU, 32'h1234, 32'd0, 32'h1234, 1);

        // Backpressure, then release with a new operation waiting.
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(OP_ADD, 32'd10, 32'd20, 32'd30);
        wait_result(n, nb);
        chk("bp_latency", n, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            chk("hold_data", bus.out_data, 32'd30);
            chk("hold_valid", bus.out_valid, 1'b1);
            chk("hold_in_ready", bus.in_ready, 1'b0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        send(OP_SUB, 32'd50, 32'd8, 32'd42);
        wait_result(n, nb);
        chk("b2b_latency", n, 1);

        // Ten back-to-back ADDs with the consumer always ready.
        @(negedge clk);
        r0 = res_cnt;
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            x = $urandom();
            y = $urandom();
            send(OP_ADD, x, y, x + y);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #3;
        chk("burst_cycles", cyc - c0, 10);
        chk("burst_results", res_cnt - r0, 10);

        // Reset in the middle of a multiply discards it.
        @(negedge clk);
        send(OP_MUL, 32'd7, 32'd9, 32'd63);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) bus.in_valid = 1'b0;
        end
        #2;
        chk("busy_in_ready", bus.in_ready, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_data", bus.out_data, '0);
        chk("mid_rst_zero", bus.out_zero, 1'b1);
        chk("mid_rst_in_ready", bus.in_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_one(OP_ADD, 32'd2, 32'd3, 32'd5, 1);

        repeat (3) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
